// File: rtl/picorv32_mem_arbiter.sv
// Shares one memory port between the picorv32 core and the vector coprocessor.
// Round-robin grant, address-range check and a stall timeout.
module picorv32_mem_arbiter #(
    parameter int unsigned ADDR_LIMIT     = 1024,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        cpu_mem_valid,
    input  logic        cpu_mem_instr,
    input  logic [31:0] cpu_mem_addr,
    input  logic [31:0] cpu_mem_wdata,
    input  logic [3:0]  cpu_mem_wstrb,
    output logic        cpu_mem_ready,
    output logic [31:0] cpu_mem_rdata,
    input  logic        vec_mem_valid,
    input  logic [31:0] vec_mem_addr,
    input  logic [31:0] vec_mem_wdata,
    input  logic [3:0]  vec_mem_wstrb,
    output logic        vec_mem_ready,
    output logic [31:0] vec_mem_rdata,
    output logic        mem_valid,
    output logic        mem_instr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        err_valid,
    output logic        err_src,
    output logic        err_code
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        GNT_CPU,
        GNT_VEC,
        ERR_CPU,
        ERR_VEC
    } state_e;

    state_e        state_q, state_d;
    logic          last_q, last_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          err_src_q, err_src_d;
    logic          err_code_q, err_code_d;

    logic sel;
    logic cand_c;
    logic cand_v;
    logic tmo;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            last_q     <= 1'b1;
            timer_q    <= '0;
            err_src_q  <= 1'b0;
            err_code_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            timer_q    <= timer_d;
            err_src_q  <= err_src_d;
            err_code_q <= err_code_d;
        end
    end

    // timer counts stall cycles already spent; abort once it reaches the limit
    assign tmo = (timer_q == TMAX) && !mem_ready;

    always_comb begin
        state_d       = state_q;
        last_d        = last_q;
        timer_d       = timer_q;
        err_src_d     = err_src_q;
        err_code_d    = err_code_q;
        sel           = 1'b0;
        cand_c        = 1'b0;
        cand_v        = 1'b0;
        mem_valid     = 1'b0;
        mem_instr     = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        mem_wstrb     = '0;
        cpu_mem_ready = 1'b0;
        cpu_mem_rdata = '0;
        vec_mem_ready = 1'b0;
        vec_mem_rdata = '0;
        err_valid     = 1'b0;

        unique case (state_q)
            IDLE: begin
                sel    = 1'b1;
                cand_c = cpu_mem_valid;
                cand_v = vec_mem_valid;
            end
            GNT_CPU: begin
                mem_valid     = !tmo;
                mem_instr     = cpu_mem_instr;
                mem_addr      = cpu_mem_addr;
                mem_wdata     = cpu_mem_wdata;
                mem_wstrb     = cpu_mem_wstrb;
                cpu_mem_ready = mem_ready || tmo;
                cpu_mem_rdata = tmo ? 32'h0 : mem_rdata;
                timer_d       = timer_q + TW'(1);
                if (tmo) begin
                    err_valid  = 1'b1;
                    err_src_d  = 1'b0;
                    err_code_d = 1'b1;
                end
                if (mem_ready || tmo) begin
                    sel    = 1'b1;
                    cand_v = vec_mem_valid;
                end
            end
            GNT_VEC: begin
                mem_valid     = !tmo;
                mem_addr      = vec_mem_addr;
                mem_wdata     = vec_mem_wdata;
                mem_wstrb     = vec_mem_wstrb;
                vec_mem_ready = mem_ready || tmo;
                vec_mem_rdata = tmo ? 32'h0 : mem_rdata;
                timer_d       = timer_q + TW'(1);
                if (tmo) begin
                    err_valid  = 1'b1;
                    err_src_d  = 1'b1;
                    err_code_d = 1'b1;
                end
                if (mem_ready || tmo) begin
                    sel    = 1'b1;
                    cand_c = cpu_mem_valid;
                end
            end
            ERR_CPU: begin
                cpu_mem_ready = 1'b1;
                err_valid     = 1'b1;
                err_src_d     = 1'b0;
                err_code_d    = 1'b0;
                sel           = 1'b1;
                cand_v        = vec_mem_valid;
            end
            ERR_VEC: begin
                vec_mem_ready = 1'b1;
                err_valid     = 1'b1;
                err_src_d     = 1'b1;
                err_code_d    = 1'b0;
                sel           = 1'b1;
                cand_c        = cpu_mem_valid;
            end
            default: state_d = IDLE;
        endcase

        // the completing requester is never a candidate, so a tie only arises in IDLE
        if (sel) begin
            state_d = IDLE;
            if (cand_c && (!cand_v || last_q)) begin
                last_d  = 1'b0;
                timer_d = '0;
                state_d = (cpu_mem_addr >= ADDR_LIMIT) ? ERR_CPU : GNT_CPU;
            end else if (cand_v) begin
                last_d  = 1'b1;
                timer_d = '0;
                state_d = (vec_mem_addr >= ADDR_LIMIT) ? ERR_VEC : GNT_VEC;
            end
        end
    end

    assign err_src  = err_src_d;
    assign err_code = err_code_d;

endmodule

// File: tb/tb_picorv32_mem_arbiter.sv
// Directed bench for picorv32_mem_arbiter with a small word memory model.
// Outputs are sampled on the falling edge, inputs driven there too.
module tb_picorv32_mem_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        cpu_mem_valid, cpu_mem_instr;
    logic [31:0] cpu_mem_addr, cpu_mem_wdata;
    logic [3:0]  cpu_mem_wstrb;
    logic        cpu_mem_ready;
    logic [31:0] cpu_mem_rdata;
    logic        vec_mem_valid;
    logic [31:0] vec_mem_addr, vec_mem_wdata;
    logic [3:0]  vec_mem_wstrb;
    logic        vec_mem_ready;
    logic [31:0] vec_mem_rdata;
    logic        mem_valid, mem_instr;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        err_valid, err_src, err_code;
    logic        mem_en;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    picorv32_mem_arbiter #(
        .ADDR_LIMIT    (1024),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .cpu_mem_valid(cpu_mem_valid),
        .cpu_mem_instr(cpu_mem_instr),
        .cpu_mem_addr (cpu_mem_addr),
        .cpu_mem_wdata(cpu_mem_wdata),
        .cpu_mem_wstrb(cpu_mem_wstrb),
        .cpu_mem_ready(cpu_mem_ready),
        .cpu_mem_rdata(cpu_mem_rdata),
        .vec_mem_valid(vec_mem_valid),
        .vec_mem_addr (vec_mem_addr),
        .vec_mem_wdata(vec_mem_wdata),
        .vec_mem_wstrb(vec_mem_wstrb),
        .vec_mem_ready(vec_mem_ready),
        .vec_mem_rdata(vec_mem_rdata),
        .mem_valid    (mem_valid),
        .mem_instr    (mem_instr),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_wstrb    (mem_wstrb),
        .mem_ready    (mem_ready),
        .mem_rdata    (mem_rdata),
        .err_valid    (err_valid),
        .err_src      (err_src),
        .err_code     (err_code)
    );

    logic [31:0] mem [256];
    bit   [255:0] written;

    function automatic logic [31:0] init_word(input logic [7:0] i);
        case (i)
            8'd0:    return 32'h00300113;
            8'd1:    return 32'h00000011;
            8'd2:    return 32'h00000022;
            8'd100:  return 32'h00020001;
            default: return 32'h5a000000 | {24'h0, i};
        endcase
    endfunction

    function automatic logic [31:0] rd(input logic [7:0] i);
        return written[i] ? mem[i] : init_word(i);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o,
                                          input logic [31:0] d,
                                          input logic [3:0]  s);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++)
            if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // one wait cycle: valid seen at an edge, ready pulsed for the next cycle
    always @(posedge clk) begin
        if (mem_ready) begin
            mem_ready <= 1'b0;
        end else if (mem_valid && mem_en) begin
            mem_ready <= 1'b1;
            mem_rdata <= rd(mem_addr[9:2]);
            if (mem_wstrb != 4'h0) begin
                mem[mem_addr[9:2]]     <= merge(rd(mem_addr[9:2]), mem_wdata, mem_wstrb);
                written[mem_addr[9:2]] <= 1'b1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        int n;
        int hi;
        bit seen;
        logic ord [8];

        resetn = 1'b0;
        mem_en = 1'b1;
        cpu_mem_valid = 0; cpu_mem_instr = 0; cpu_mem_addr = 0;
        cpu_mem_wdata = 0; cpu_mem_wstrb = 0;
        vec_mem_valid = 0; vec_mem_addr = 0;
        vec_mem_wdata = 0; vec_mem_wstrb = 0;
        repeat (2) tick();
        check("rst_valid", mem_valid, 0);
        check("rst_cpu_rdy", cpu_mem_ready, 0);
        check("rst_vec_rdy", vec_mem_ready, 0);
        check("rst_err", err_valid, 0);
        check("rst_src", err_src, 0);
        check("rst_code", err_code, 0);
        check("rst_addr", mem_addr, 0);

        // CPU fetch of address 0
        resetn = 1'b1;
        cpu_mem_valid = 1; cpu_mem_instr = 1; cpu_mem_addr = 0;
        tick();
        check("t1_valid", mem_valid, 1);
        check("t1_addr", mem_addr, 0);
        check("t1_instr", mem_instr, 1);
        check("t1_early_rdy", cpu_mem_ready, 0);
        tick();
        check("t1_rdy", cpu_mem_ready, 1);
        check("t1_rdata", cpu_mem_rdata, 32'h00300113);
        check("t1_vec_rdy", vec_mem_ready, 0);
        cpu_mem_valid = 0; cpu_mem_instr = 0;
        tick();
        check("t1_idle", mem_valid, 0);

        // both requesting right after reset
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        cpu_mem_valid = 1; cpu_mem_addr = 4;
        vec_mem_valid = 1; vec_mem_addr = 8;
        tick();
        check("t2_cpu_first", mem_addr, 4);
        check("t2_valid", mem_valid, 1);
        tick();
        check("t2_cpu_rdy", cpu_mem_ready, 1);
        check("t2_cpu_rdata", cpu_mem_rdata, 32'h11);
        check("t2_vec_wait", vec_mem_ready, 0);
        cpu_mem_valid = 0;
        tick();
        check("t2_no_bubble", mem_valid, 1);
        check("t2_vec_addr", mem_addr, 8);
        tick();
        check("t2_vec_rdy", vec_mem_ready, 1);
        check("t2_vec_rdata", vec_mem_rdata, 32'h22);
        check("t2_cpu_quiet", cpu_mem_ready, 0);
        vec_mem_valid = 0;
        tick();

        // continuous contention: strict alternation
        cpu_mem_valid = 1; cpu_mem_addr = 0;
        vec_mem_valid = 1; vec_mem_addr = 8;
        n = 0;
        for (int c = 0; c < 80 && n < 8; c++) begin
            tick();
            if (cpu_mem_ready) begin
                ord[n] = 1'b0; n++;
            end else if (vec_mem_ready) begin
                ord[n] = 1'b1; n++;
            end
        end
        cpu_mem_valid = 0; vec_mem_valid = 0;
        check("rr_count", n, 8);
        for (int i = 0; i < n; i++)
            check("rr_order", {31'h0, ord[i]}, i % 2);
        tick();
        check("rr_idle", mem_valid, 0);

        // VEC partial write while CPU waits
        vec_mem_valid = 1; vec_mem_addr = 400;
        vec_mem_wdata = 32'h0000abcd; vec_mem_wstrb = 4'b0011;
        tick();
        check("t4_addr", mem_addr, 400);
        check("t4_wstrb", mem_wstrb, 4'b0011);
        check("t4_wdata", mem_wdata, 32'h0000abcd);
        check("t4_instr", mem_instr, 0);
        cpu_mem_valid = 1; cpu_mem_addr = 12;
        tick();
        check("t4_vec_rdy", vec_mem_ready, 1);
        check("t4_cpu_stall", cpu_mem_ready, 0);
        vec_mem_valid = 0; vec_mem_wstrb = 0;
        tick();
        check("t4_cpu_gnt", mem_addr, 12);
        check("t4_cpu_wait", cpu_mem_ready, 0);
        tick();
        check("t4_cpu_rdata", cpu_mem_rdata, 32'h5a000003);
        cpu_mem_valid = 0;
        check("t4_word", rd(8'd100), 32'h0002abcd);
        tick();

        // range boundary
        cpu_mem_valid = 1; cpu_mem_addr = 1020;
        tick();
        check("lim_in", mem_valid, 1);
        tick();
        check("lim_in_rdy", cpu_mem_ready, 1);
        cpu_mem_valid = 0;
        tick();
        cpu_mem_valid = 1; cpu_mem_addr = 1024;
        tick();
        check("oor_valid", mem_valid, 0);
        check("oor_rdy", cpu_mem_ready, 1);
        check("oor_rdata", cpu_mem_rdata, 0);
        check("oor_err", err_valid, 1);
        check("oor_src", err_src, 0);
        check("oor_code", err_code, 0);
        cpu_mem_valid = 0;
        tick();
        check("oor_pulse", err_valid, 0);
        check("oor_one_rdy", cpu_mem_ready, 0);
        vec_mem_valid = 1; vec_mem_addr = 2000;
        tick();
        check("voor_rdy", vec_mem_ready, 1);
        check("voor_src", err_src, 1);
        check("voor_valid", mem_valid, 0);
        vec_mem_valid = 0;
        tick();
        check("voor_hold_src", err_src, 1);
        check("voor_hold_code", err_code, 0);
        check("voor_pulse", err_valid, 0);

        // stall timeout
        mem_en = 1'b0;
        vec_mem_valid = 1; vec_mem_addr = 16;
        hi = 0;
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (vec_mem_ready) begin
                seen = 1;
                check("to_rdata", vec_mem_rdata, 0);
                check("to_err", err_valid, 1);
                check("to_src", err_src, 1);
                check("to_code", err_code, 1);
                check("to_valid_low", mem_valid, 0);
                break;
            end
            if (mem_valid) hi++;
        end
        check("to_seen", {31'h0, seen}, 1);
        check("to_high_cycles", hi, 8);
        vec_mem_valid = 0;
        tick();
        check("to_idle", mem_valid, 0);

        // async reset mid-grant
        vec_mem_valid = 1;
        repeat (3) tick();
        check("ar_pre", mem_valid, 1);
        #2 resetn = 1'b0;
        #1;
        check("ar_drop", mem_valid, 0);
        check("ar_rdy", vec_mem_ready, 0);
        vec_mem_valid = 0;
        tick();
        resetn = 1'b1;
        tick();
        check("ar_after", mem_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
